// File: rtl/key_schedule_slow_pkg.sv
// Shared constants, S-box tables and state type for the Serpent key schedule.
// Optional feature: SERPENT_KS_IP_EN applies the initial permutation to subkeys.
package key_schedule_slow_pkg;

    localparam logic [31:0] PHI         = 32'h9E3779B9;
    localparam int          NUM_SUBKEYS = 33;
    localparam int          LAST_WORD   = 131;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } ks_state_t;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB,
          4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA,
          4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF,
          4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3,
          4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6,
          4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC,
          4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB,
          4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB,
          4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    // Initial permutation: output bit 4k+m takes bit k of word m.
    function automatic logic [127:0] serpent_ip(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int k = 0; k < 32; k++) begin
            for (int m = 0; m < 4; m++) begin
                y[4*k+m] = x[32*m+k];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/key_schedule_slow_sbox_slice.sv
// Bitsliced Serpent S-box over four 32-bit words; x0 is the LSB word.
// Purely combinational, the S-box is chosen by a 3-bit select.
module serpent_sbox_slice
    import key_schedule_slow_pkg::*;
(
    input  logic [2:0]   sel,
    input  logic [31:0]  x0,
    input  logic [31:0]  x1,
    input  logic [31:0]  x2,
    input  logic [31:0]  x3,
    output logic [127:0] y
);

    logic [3:0] nib;

    // Each bit column forms one nibble, substituted and scattered back.
    always_comb begin
        y   = '0;
        nib = '0;
        for (int b = 0; b < 32; b++) begin
            nib = SBOX[sel][{x3[b], x2[b], x1[b], x0[b]}];
            y[b]      = nib[0];
            y[32 + b] = nib[1];
            y[64 + b] = nib[2];
            y[96 + b] = nib[3];
        end
    end

endmodule

// File: rtl/key_schedule_slow.sv
// Serial Serpent key schedule: one prekey word per cycle, a subkey every 4.
// Define SERPENT_KS_IP_EN to emit subkeys in standard (IP) form.
module key_schedule_slow
    import key_schedule_slow_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_begin,
    input  logic [255:0] i_key,
    output logic [127:0] o_subkey,
    output logic [5:0]   o_address,
    output logic         o_subkey_valid
);

    localparam logic [7:0] LAST_J = 8'(LAST_WORD);

    ks_state_t    state;
    logic [31:0]  win [8];
    logic [7:0]   j;
    logic [31:0]  mix;
    logic [31:0]  w_new;
    logic [2:0]   sel;
    logic [127:0] sliced;
    logic [127:0] subkey_d;

    // Next prekey word from the sliding window; win[k] holds w(j-8+k).
    always_comb begin
        mix   = win[0] ^ win[3] ^ win[5] ^ win[7] ^ PHI ^ {24'd0, j};
        w_new = {mix[20:0], mix[31:21]};
    end

    // Subkey i uses S-box (3 - i) mod 8, with i = j / 4.
    assign sel = 3'd3 - j[4:2];

    serpent_sbox_slice u_sbox (
        .sel (sel),
        .x0  (win[5]),
        .x1  (win[6]),
        .x2  (win[7]),
        .x3  (w_new),
        .y   (sliced)
    );

`ifdef SERPENT_KS_IP_EN
    assign subkey_d = serpent_ip(sliced);
`else
    assign subkey_d = sliced;
`endif

    // Control FSM, prekey window shift and registered subkey outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            j              <= '0;
            o_subkey       <= '0;
            o_address      <= '0;
            o_subkey_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                win[k] <= '0;
            end
        end else begin
            o_subkey_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_begin) begin
                        for (int k = 0; k < 8; k++) begin
                            win[k] <= i_key[32*k +: 32];
                        end
                        j     <= '0;
                        state <= GEN;
                    end
                end
                GEN: begin
                    for (int k = 0; k < 7; k++) begin
                        win[k] <= win[k+1];
                    end
                    win[7] <= w_new;
                    j      <= j + 8'd1;
                    if (j[1:0] == 2'b11) begin
                        o_subkey       <= subkey_d;
                        o_address      <= j[7:2];
                        o_subkey_valid <= 1'b1;
                    end
                    if (j == LAST_J) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_slow.sv
// Directed bench for key_schedule_slow with a behavioural Serpent model.
// Follows the SERPENT_KS_IP_EN build setting of the design.
module tb_key_schedule_slow;

    logic         i_clk;
    logic         i_rst;
    logic         i_begin;
    logic [255:0] i_key;
    logic [127:0] o_subkey;
    logic [5:0]   o_address;
    logic         o_subkey_valid;

    int checks = 0;
    int errors = 0;
    int cur_n  = 0;

    logic [127:0] exp_sk [33];

    localparam logic [3:0] SB [8][16] = '{
        '{4'h3, 4'h8, 4'hF, 4'h1, 4'hA, 4'h6, 4'h5, 4'hB,
          4'hE, 4'hD, 4'h4, 4'h2, 4'h7, 4'h0, 4'h9, 4'hC},
        '{4'hF, 4'hC, 4'h2, 4'h7, 4'h9, 4'h0, 4'h5, 4'hA,
          4'h1, 4'hB, 4'hE, 4'h8, 4'h6, 4'hD, 4'h3, 4'h4},
        '{4'h8, 4'h6, 4'h7, 4'h9, 4'h3, 4'hC, 4'hA, 4'hF,
          4'hD, 4'h1, 4'hE, 4'h4, 4'h0, 4'hB, 4'h5, 4'h2},
        '{4'h0, 4'hF, 4'hB, 4'h8, 4'hC, 4'h9, 4'h6, 4'h3,
          4'hD, 4'h1, 4'h2, 4'h4, 4'hA, 4'h7, 4'h5, 4'hE},
        '{4'h1, 4'hF, 4'h8, 4'h3, 4'hC, 4'h0, 4'hB, 4'h6,
          4'h2, 4'h5, 4'h4, 4'hA, 4'h9, 4'hE, 4'h7, 4'hD},
        '{4'hF, 4'h5, 4'h2, 4'hB, 4'h4, 4'hA, 4'h9, 4'hC,
          4'h0, 4'h3, 4'hE, 4'h8, 4'hD, 4'h6, 4'h7, 4'h1},
        '{4'h7, 4'h2, 4'hC, 4'h5, 4'h8, 4'h4, 4'h6, 4'hB,
          4'hE, 4'h9, 4'h1, 4'hF, 4'hD, 4'h3, 4'hA, 4'h0},
        '{4'h1, 4'hD, 4'hF, 4'h0, 4'hE, 4'h8, 4'h2, 4'hB,
          4'h7, 4'h4, 4'hC, 4'hA, 4'h9, 4'h3, 4'h5, 4'h6}
    };

    localparam logic [255:0] K1 =
        256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
    localparam logic [255:0] K2 =
        256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [255:0] K3 =
        256'hdeadbeefcafebabe0000000100000000ffffffff123456789abcdef011111111;
    localparam logic [255:0] K4 =
        256'h8000000000000000000000000000000000000000000000000000000000000001;
    localparam logic [255:0] K5 =
        256'h00000000000000000000000000000000000000000000000000000000000000ff;

    key_schedule_slow dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_begin        (i_begin),
        .i_key          (i_key),
        .o_subkey       (o_subkey),
        .o_address      (o_address),
        .o_subkey_valid (o_subkey_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d: observed %h expected %h",
                   tag, cur_n, obs, exp);
        end
    endtask

    // Reference schedule built from the full prekey array w(-8..131).
    task automatic compute_model(input logic [255:0] k);
        logic [31:0]  w [140];
        logic [31:0]  t;
        logic [31:0]  a, b, c, d;
        logic [3:0]   v;
        logic [127:0] s;
        int           sb;
        for (int m = 0; m < 8; m++) w[m] = k[32*m +: 32];
        for (int jj = 0; jj < 132; jj++) begin
            t = w[jj] ^ w[jj+3] ^ w[jj+5] ^ w[jj+7] ^ 32'h9E3779B9 ^ 32'(jj);
            w[jj+8] = {t[20:0], t[31:21]};
        end
        for (int i = 0; i < 33; i++) begin
            a  = w[4*i+8];
            b  = w[4*i+9];
            c  = w[4*i+10];
            d  = w[4*i+11];
            sb = (35 - i) % 8;
            s  = '0;
            for (int bit_i = 0; bit_i < 32; bit_i++) begin
                v = SB[sb][{d[bit_i], c[bit_i], b[bit_i], a[bit_i]}];
                s[bit_i]      = v[0];
                s[32 + bit_i] = v[1];
                s[64 + bit_i] = v[2];
                s[96 + bit_i] = v[3];
            end
`ifdef SERPENT_KS_IP_EN
            exp_sk[i] = '0;
            for (int p = 0; p < 127; p++) exp_sk[i][p] = s[(32*p) % 127];
            exp_sk[i][127] = s[127];
`else
            exp_sk[i] = s;
`endif
        end
    endtask

    // Called #1 after an edge; the next edge is edge 0 of the schedule.
    task automatic start(input logic [255:0] k);
        i_key   = k;
        i_begin = 1'b1;
        @(posedge i_clk);
        #1;
        i_begin = 1'b0;
        cur_n   = 0;
        chk("start_valid", 128'(o_subkey_valid), 128'd0);
    endtask

    task automatic expect_schedule(input logic [255:0] k, input int stop_at,
                                   input int busy_at,
                                   input logic [255:0] busy_key);
        bit ev;
        compute_model(k);
        for (int n = 1; n <= stop_at; n++) begin
            @(posedge i_clk);
            #1;
            cur_n   = n;
            i_begin = (n == busy_at);
            if (n == busy_at) i_key = busy_key;
            ev = (n % 4 == 0);
            chk("valid", 128'(o_subkey_valid), 128'(ev));
            if (ev) begin
                chk("address", 128'(o_address), 128'(n / 4 - 1));
                chk("subkey", o_subkey, exp_sk[n / 4 - 1]);
            end
        end
        i_begin = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge i_clk);
            #1;
            if (o_subkey_valid) pulses++;
        end
        chk(tag, 128'(pulses), 128'd0);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_begin = 1'b0;
        i_key   = '0;
        #1;
        chk("rst_subkey", o_subkey, 128'd0);
        chk("rst_address", 128'(o_address), 128'd0);
        chk("rst_valid", 128'(o_subkey_valid), 128'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle_check("idle_after_reset", 5);

        start(K1);
        expect_schedule(K1, 132, 0, '0);

        start(K2);
        expect_schedule(K2, 132, 49, K3);
        idle_check("idle_after_busy", 4);

        start('0);
        expect_schedule('0, 132, 131, K1);
        idle_check("late_begin_ignored", 8);

        start(K4);
        expect_schedule(K4, 60, 0, '0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst_subkey", o_subkey, 128'd0);
        chk("midrst_address", 128'(o_address), 128'd0);
        chk("midrst_valid", 128'(o_subkey_valid), 128'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        idle_check("idle_after_midrst", 20);

        start(K5);
        expect_schedule(K5, 132, 0, '0);
        idle_check("idle_at_end", 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_slow.md
KEY_SCHEDULE_SLOW -- requirements
Module: key_schedule_slow

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port i_begin, input, 1 bit: start request, sampled on rising i_clk.
REQ-004 SHALL have port i_key, input, 256 bits: full Serpent user key; the caller pads short keys per the Serpent rule.
REQ-005 SHALL have port o_subkey, output, 128 bits: current round subkey K_i.
REQ-006 SHALL have port o_address, output, 6 bits: subkey index i, range 0..32.
REQ-007 SHALL have port o_subkey_valid, output, 1 bit: one-cycle strobe qualifying o_subkey and o_address.

Function
REQ-008 SHALL implement two states: IDLE and GEN.
REQ-009 In IDLE, i_begin=1 SHALL latch i_key into the prekey window, clear the word counter j, and enter GEN.
REQ-010 Key word mapping SHALL be: w(-8)=i_key[31:0] up to w(-1)=i_key[255:224].
REQ-011 In GEN, exactly one prekey word per cycle SHALL be computed: w(j) = ROL11(w(j-8) ^ w(j-5) ^ w(j-3) ^ w(j-1) ^ 0x9E3779B9 ^ j).
- Arithmetic is 32-bit; j runs 0..131.
- The 8-word window shifts after each word.
REQ-012 The cycle that produces w(4i+3) SHALL also register the subkey:
- o_subkey = S_((3-i) mod 8) applied bitsliced to {w(4i+3), w(4i+2), w(4i+1), w(4i)}.
- w(4i) is the LSB word.
- S-box input bit b is formed from bit b of each of the four words.
REQ-013 On that same edge, o_address SHALL be set to i and o_subkey_valid SHALL be set to 1 for exactly one cycle.
REQ-014 Latency: subkey i SHALL be valid in the cycle after edge 4i+4, counting the i_begin-sampling edge as edge 0.
- Subkey 0 is valid after edge 4.
- Subkey 32 is valid after edge 132.
- Valid pulses are therefore spaced 4 cycles apart.
REQ-015 After subkey 32 is issued (o_address=32), the block SHALL return to IDLE.
REQ-016 i_begin asserted while in GEN SHALL be ignored; the current schedule always completes.
REQ-017 i_begin asserted in the same cycle that GEN returns to IDLE SHALL be ignored; a new start is accepted only in a cycle where the block is in IDLE.
REQ-018 Outside valid cycles, o_subkey and o_address SHALL hold their last values; o_subkey_valid SHALL be 0.

Reset
REQ-019 i_rst=1 SHALL asynchronously force the following values:
- state = IDLE
- prekey window = 0 and counter = 0
- o_subkey = 0
- o_address = 0
- o_subkey_valid = 0
REQ-020 Reset asserted mid-GEN SHALL abort the schedule with no further valid pulses; a fresh i_begin is required after release.

Configuration
REQ-021 With macro SERPENT_KS_IP_EN defined, each subkey SHALL pass through the Serpent initial permutation IP before registering (standard, non-bitsliced form).
REQ-022 Without SERPENT_KS_IP_EN, subkeys SHALL be output in bitsliced form without IP; timing SHALL be identical in both builds.

Structure
REQ-023 A shared package SHALL hold:
- PHI = 32'h9E3779B9
- NUM_SUBKEYS = 33
- LAST_WORD = 131
- the eight 4-bit S-box tables
- the state enum type
REQ-024 A combinational sub-module serpent_sbox_slice SHALL apply a selected S-box (3-bit select) to four 32-bit words; one instance, reused every cycle.

Verification
REQ-025 Reset check: assert i_rst mid-cycle -> all outputs 0 immediately; no o_subkey_valid until a new i_begin.
REQ-026 Full-schedule check: i_key = 256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100, i_begin held for 1 cycle.
- Required: exactly 33 valid pulses, 4 cycles apart, with o_address = 0..32 in order.
- Subkey 0 valid 4 cycles after start.
- Each o_subkey matches the reference Serpent model.
REQ-027 All-zero key check: i_key=0 -> subkeys match the published Serpent 256-bit zero-key schedule, in both SERPENT_KS_IP_EN builds.
REQ-028 Busy-start check: i_begin pulsed again at cycle 50 with a different key -> ignored; the original key's 33 subkeys complete unchanged.
REQ-029 Mid-run reset check: i_rst at cycle 60, then i_begin with a new key -> a fresh schedule starts at o_address=0 with correct subkeys.
REQ-030 Back-to-back check: i_begin at the first IDLE cycle after o_address=32 -> second schedule accepted with identical timing.
